dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- MEM-stage data-memory access unit. It is the responder for the decoder's memory controls (memRead, dm_w_en, func3).
- Turns one load/store request into a single word-aligned bus transaction with a req/ack handshake.
- Shifts byte enables and store data into their lanes, and sign- or zero-extends load data.
- Holds the pipeline stalled until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, REQ-state cycles without bus_ack before abort (used only with BUS_TIMEOUT_EN).

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
mem_read  input  1  load request (decoder memRead)
dm_w_en  input  4  unshifted store mask from decoder: 0001 sb, 0011 sh, 1111 sw, 0000 none
func3  input  3  access size/sign (inst[14:12])
addr  input  32  effective byte address (ALU result)
wdata  input  32  store data (rs2)
stall  output  1  hold IF/ID/EX/MEM registers
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle pulse; rdata is valid
misalign  output  1  one-cycle pulse; request dropped
bus_req  output  1  bus request
bus_we  output  4  lane-shifted byte write enables (0 for loads)
bus_addr  output  32  {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  bus completion
bus_rdata  input  32  bus read word
bus_err  output  1  timeout pulse (always 0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0, state IDLE. Reset during REQ aborts the access and drops bus_req at the next edge; no completion pulse follows.
- Request detection: request = mem_read | (dm_w_en != 0). If both are set, the access is a store (bus_we nonzero); no read data is returned.
- Alignment check:
  - lh/lhu/sh are misaligned if addr[0] = 1.
  - lw/sw are misaligned if addr[1:0] != 0.
  - byte accesses are never misaligned.
- Store formatting:
  - bus_we = dm_w_en << addr[1:0].
  - bus_wdata: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Aligned request: latch addr, func3, bus_we, bus_wdata and the access type; go to REQ. stall = 1 combinationally in this cycle.
  - Misaligned request: misalign = 1 for this cycle, stall = 0, no bus activity, rdata_valid = 0, state stays IDLE.
  - No request: stall = 0.
- REQ:
  - bus_req = 1 with bus_addr, bus_we and bus_wdata held stable.
  - stall = 1.
  - On bus_ack: load path captures bus_rdata, then go to DONE.
- DONE:
  - stall = 0, so the pipeline advances at the end of this cycle.
  - rdata_valid = 1 for loads only.
  - Inputs are ignored (the stale instruction is still present); next state is IDLE.
- Latency: request in cycle T, bus_req from T+1. With ack at T+1, DONE is T+2, so minimum stall is 2 cycles.
- bus_ack outside REQ is ignored.
- Load extension. Byte b = word >> (8*addr[1:0]); half h = word >> (8*addr[1:0]).
  - 000 lb: sign-extend b[7:0].
  - 001 lh: sign-extend h[15:0].
  - 010 lw: full word.
  - 100 lbu: zero-extend b[7:0].
  - 101 lhu: zero-extend h[15:0].
  - any other func3: 0.
- rdata holds its value until the next load completes.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop bus_req, pulse bus_err for 1 cycle, force rdata = 0, and go to DONE. rdata_valid still pulses for loads.
  - An ack in the same cycle as the timeout takes priority and counts as a normal completion.
- Undefined: no counter, REQ waits indefinitely, and bus_err is tied 0.

Test Plan:
- lw, addr 0x100, bus_rdata 0xDEADBEEF, ack on first REQ cycle -> stall high 2 cycles; bus_addr 0x100, bus_we 0000; rdata 0xDEADBEEF with rdata_valid pulse in DONE.
- lb addr 0x103 then lbu addr 0x103, bus_rdata 0x80FF1234 -> rdata 0xFFFFFF80, then 0x00000080.
- sh addr 0x202, wdata 0x0000ABCD, ack after 3 wait cycles -> bus_addr 0x200, bus_we 1100, bus_wdata 0xABCDABCD, stall high 5 cycles, no rdata_valid.
- sw addr 0x301 -> misalign pulse, bus_req never asserts, stall 0; then sb addr 0x301 -> bus_we 0010.
- rst asserted on the second REQ cycle of a load -> bus_req 0 next cycle, state IDLE, no rdata_valid; a later lw completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with no ack -> bus_err pulse after 4 REQ cycles, rdata 0 with rdata_valid, stall released in DONE.

Source files
------------

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
//
// MEM-stage data-memory access unit. Each load/store request from the decoder
// (mem_read, dm_w_en, func3) becomes one word-aligned bus transaction with a
// req/ack handshake. Store data and byte enables are steered into their lanes,
// and load data is sign- or zero-extended. The pipeline stays stalled until
// the access completes.
//
// Optional feature (compile-time macro BUS_TIMEOUT_EN):
//   defined   - a REQ-state watchdog aborts the access after TIMEOUT_CYCLES
//               cycles without bus_ack, pulses bus_err and returns rdata = 0
//   undefined - REQ waits indefinitely for bus_ack; bus_err is tied 0
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles without bus_ack before abort (BUS_TIMEOUT_EN)
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   mem_read      load request
//   dm_w_en[3:0]  unshifted store mask (0001 sb, 0011 sh, 1111 sw, 0000 none)
//   func3[2:0]    access size / sign
//   addr[31:0]    effective byte address
//   wdata[31:0]   store data
//   stall         hold IF/ID/EX/MEM pipeline registers
//   rdata[31:0]   extended load result (holds until the next load completes)
//   rdata_valid   one-cycle pulse: rdata updated by a load
//   misalign      one-cycle pulse: request dropped, no bus activity
//   bus_req       bus request
//   bus_we[3:0]   lane-shifted byte write enables (0 for loads)
//   bus_addr      word-aligned bus address
//   bus_wdata     lane-replicated store data
//   bus_ack       bus completion (ignored outside REQ)
//   bus_rdata     bus read word
//   bus_err       timeout pulse
// -----------------------------------------------------------------------------
module dm_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic [3:0]  dm_w_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t      state;

  // Attributes of the access in flight, latched when the request is accepted.
  logic        req_load;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;

  // ---------------------------------------------------------------------------
  // Request decode, alignment check and store formatting (IDLE-cycle inputs)
  // ---------------------------------------------------------------------------
  logic        has_req;
  logic        is_load_in;
  logic        misaligned_in;
  logic        accept;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_wdata;

  // A store mask wins over mem_read: such an access is a store and returns no data.
  assign has_req    = mem_read | (|dm_w_en);
  assign is_load_in = mem_read & ~(|dm_w_en);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    misaligned_in = 1'b0;
    fmt_wdata     = wdata;
    unique case (func3[1:0])
      2'b00: fmt_wdata = {4{wdata[7:0]}};
      2'b01: begin
        misaligned_in = addr[0];
        fmt_wdata     = {2{wdata[15:0]}};
      end
      2'b10: misaligned_in = |addr[1:0];
      default: ;
    endcase
  end

  assign fmt_we = dm_w_en << addr[1:0];
  assign accept = (state == S_IDLE) && has_req && !misaligned_in;

  // Stall is combinational in IDLE so the pipeline freezes in the same cycle
  // the request appears; it stays up through REQ and is released in DONE.
  assign stall    = !rst && (accept || (state == S_REQ));
  assign misalign = !rst && (state == S_IDLE) && has_req && misaligned_in;

  // ---------------------------------------------------------------------------
  // Load extension: select the addressed byte/half from the bus word.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = word;
      3'b100:  extend_load = {24'h0, sh[7:0]};
      3'b101:  extend_load = {16'h0, sh[15:0]};
      default: extend_load = 32'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Optional REQ watchdog
  // ---------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;
  logic             timeout_hit;

  // wait_cnt holds the number of ack-less REQ cycles already seen, so the
  // current cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err     = bus_err_q;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign bus_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Access FSM with registered bus and result outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_load    <= 1'b0;
      req_f3      <= 3'b000;
      req_off     <= 2'b00;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 4'h0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt    <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          rdata_valid <= 1'b0;
          if (accept) begin
            req_load  <= is_load_in;
            req_f3    <= func3;
            req_off   <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= fmt_we;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= fmt_wdata;
`ifdef BUS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          // An ack in the timeout cycle is checked first and completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (req_load) begin
              rdata       <= extend_load(bus_rdata, req_off, req_f3);
              rdata_valid <= 1'b1;
            end
            state <= S_DONE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_req   <= 1'b0;
            bus_err_q <= 1'b1;
            if (req_load) begin
              rdata       <= 32'h0;
              rdata_valid <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          // The stalled instruction is still on the inputs; ignore it.
          rdata_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          bus_err_q   <= 1'b0;
`endif
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
//
// Directed test of dm_access_unit. The stimulus process pushes the expected
// bus transaction, load result, stall length, misalign and bus_err events into
// queues before issuing each request; a monitor on the falling clock edge pops
// and compares whenever the DUT presents the matching output. A bus responder
// answers bus_req after a programmable number of wait cycles.
// Define BUS_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [3:0]  dm_w_en;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  dm_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .dm_w_en    (dm_w_en),
    .func3      (func3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .misalign   (misalign),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-event queues: {bus_addr, bus_we, bus_wdata}, rdata, stall length,
  // misalign, and REQ-cycle count before bus_err.
  logic [67:0] q_bus[$];
  logic [31:0] q_rd[$];
  int          q_stall[$];
  int          q_mis[$];
  int          q_err[$];

  // ---------------------------------------------------------------------------
  // Bus responder: ack after ack_delay wait cycles while ack_en is set.
  // ---------------------------------------------------------------------------
  int ack_delay = 0;
  bit ack_en    = 1'b1;
  int resp_cnt  = 0;

  always @(negedge clk) begin
    if (bus_req && ack_en) begin
      if (resp_cnt == ack_delay) begin
        bus_ack  = 1'b1;
        resp_cnt = 0;
      end else begin
        bus_ack  = 1'b0;
        resp_cnt = resp_cnt + 1;
      end
    end else begin
      bus_ack  = 1'b0;
      resp_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit prev_req  = 1'b0;
  int stall_run = 0;
  int req_run   = 0;

  always @(negedge clk) begin
    logic [67:0] eb;
    logic [31:0] er;
    int          ei;

    if (bus_req && !prev_req) begin
      req_run = 0;
      if (q_bus.size() == 0) begin
        check("unexpected_bus_req", {32'h0, bus_addr}, 64'h0);
      end else begin
        eb = q_bus.pop_front();
        check("bus_addr",  {32'h0, bus_addr},  {32'h0, eb[67:36]});
        check("bus_we",    {60'h0, bus_we},    {60'h0, eb[35:32]});
        check("bus_wdata", {32'h0, bus_wdata}, {32'h0, eb[31:0]});
      end
    end
    if (bus_req) req_run++;
    prev_req = bus_req;

    if (rdata_valid) begin
      if (q_rd.size() == 0) begin
        check("unexpected_rdata_valid", {32'h0, rdata}, 64'h0);
      end else begin
        er = q_rd.pop_front();
        check("rdata", {32'h0, rdata}, {32'h0, er});
      end
    end

    if (misalign) begin
      if (q_mis.size() == 0) begin
        check("unexpected_misalign", 64'(misalign), 64'h0);
      end else begin
        ei = q_mis.pop_front();
        check("misalign_quiet", {62'h0, stall, bus_req}, 64'h0);
      end
    end

    if (bus_err) begin
      if (q_err.size() == 0) begin
        check("unexpected_bus_err", 64'(bus_err), 64'h0);
      end else begin
        ei = q_err.pop_front();
        check("bus_err_req_cycles", 64'(req_run), 64'(ei));
      end
    end

    if (stall) begin
      stall_run++;
    end else if (stall_run > 0) begin
      if (q_stall.size() == 0) begin
        check("unexpected_stall", 64'(stall_run), 64'h0);
      end else begin
        ei = q_stall.pop_front();
        check("stall_cycles", 64'(stall_run), 64'(ei));
      end
      stall_run = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    mem_read = 1'b0;
    dm_w_en  = 4'h0;
    func3    = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;
  endtask

  // Present one request and hold it, as a stalled pipeline would, until the
  // cycle in which stall is released (DONE, or the misaligned cycle itself).
  task automatic access(input logic mr, input logic [3:0] we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] brd, input int delay);
    int guard;
    ack_delay = delay;
    bus_rdata = brd;
    @(posedge clk); #1;
    mem_read = mr;
    dm_w_en  = we;
    func3    = f3;
    addr     = a;
    wdata    = wd;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (stall && guard < 64);
    if (guard >= 64) check("stall_release", 64'(stall), 64'h0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    rst       = 1'b1;
    bus_rdata = 32'h0;
    clear_inputs();
    mem_read  = 1'b1;  // a request during reset must not raise stall
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall",       64'(stall),        64'h0);
    check("reset_misalign",    64'(misalign),     64'h0);
    check("reset_bus_req",     64'(bus_req),      64'h0);
    check("reset_rdata_valid", 64'(rdata_valid),  64'h0);
    check("reset_bus_err",     64'(bus_err),      64'h0);
    check("reset_rdata",       {32'h0, rdata},    64'h0);
    check("reset_bus_we",      {60'h0, bus_we},   64'h0);
    check("reset_bus_addr",    {32'h0, bus_addr}, 64'h0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;

    // lw 0x100, ack on first REQ cycle
    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'hDEADBEEF);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);

    // lb / lbu 0x103 on 0x80FF1234
    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'hFFFFFF80);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);

    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'h00000080);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);

    // lh 0x102 (upper half, sign bit set) and lhu 0x100
    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'hFFFF80FF);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0);

    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'h00001234);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0);

    // sh 0x202, ack after 3 wait cycles
    q_bus.push_back({32'h200, 4'b1100, 32'hABCDABCD});
    q_stall.push_back(5);
    access(1'b0, 4'b0011, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3);

    // sw 0x301 misaligned, then sb 0x301
    q_mis.push_back(1);
    access(1'b0, 4'b1111, 3'b010, 32'h301, 32'h11223344, 32'h0, 0);

    q_bus.push_back({32'h300, 4'b0010, 32'h5A5A5A5A});
    q_stall.push_back(3);
    access(1'b0, 4'b0001, 3'b000, 32'h301, 32'h0000005A, 32'h0, 1);

    // lh 0x101 misaligned
    q_mis.push_back(1);
    access(1'b1, 4'b0000, 3'b001, 32'h101, 32'h0, 32'h0, 0);

    // mem_read together with a store mask is a store: no read data
    q_bus.push_back({32'h500, 4'b1111, 32'hCAFEF00D});
    q_stall.push_back(2);
    access(1'b1, 4'b1111, 3'b010, 32'h500, 32'hCAFEF00D, 32'h55555555, 0);

    // Unsupported load func3 returns 0
    q_bus.push_back({32'h100, 4'b0000, 32'h0});
    q_rd.push_back(32'h0);
    q_stall.push_back(2);
    access(1'b1, 4'b0000, 3'b011, 32'h100, 32'h0, 32'hDEADBEEF, 0);

    // Reset on the second REQ cycle of a load
    ack_en = 1'b0;
    q_bus.push_back({32'h400, 4'b0000, 32'h0});
    q_stall.push_back(2);
    @(posedge clk); #1;
    mem_read = 1'b1;
    func3    = 3'b010;
    addr     = 32'h400;
    @(posedge clk); #1;  // REQ cycle 1
    @(posedge clk); #1;  // REQ cycle 2
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_bus_req", 64'(bus_req), 64'h0);
    check("post_reset_stall",   64'(stall),   64'h0);
    repeat (3) @(negedge clk);
    ack_en = 1'b1;

    // Normal lw after the aborted access
    q_bus.push_back({32'h104, 4'b0000, 32'h0});
    q_rd.push_back(32'h12345678);
    q_stall.push_back(3);
    access(1'b1, 4'b0000, 3'b010, 32'h104, 32'h0, 32'h12345678, 1);

`ifdef BUS_TIMEOUT_EN
    // Load with no ack: watchdog fires after 4 REQ cycles
    ack_en = 1'b0;
    q_bus.push_back({32'h600, 4'b0000, 32'h0});
    q_rd.push_back(32'h0);
    q_err.push_back(4);
    q_stall.push_back(5);
    access(1'b1, 4'b0000, 3'b010, 32'h600, 32'h0, 32'hFFFFFFFF, 0);
    ack_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("pending_bus",   64'(q_bus.size()),   64'h0);
    check("pending_rdata", 64'(q_rd.size()),    64'h0);
    check("pending_stall", 64'(q_stall.size()), 64'h0);
    check("pending_mis",   64'(q_mis.size()),   64'h0);
    check("pending_err",   64'(q_err.size()),   64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
